// File: rtl/lc3b_types.sv
// lc3b_types: shared pipeline control state encoding and parameter defaults.
package lc3b_types;
  localparam int NUM_STAGES_DEF = 5;
  localparam int MEM_STAGE_DEF  = 3;
  localparam int CNT_WIDTH_DEF  = 16;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ISTALL = 2'd1,
    DSTALL = 2'd2,
    FLUSH  = 2'd3
  } lc3b_pipe_state;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: memory handshakes, redirect request and pipeline control outputs.
interface pipeline_ctrl_if
  import lc3b_types::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);
  logic                  imem_resp;
  logic                  dmem_req;
  logic                  dmem_resp;
  logic                  branch_taken;
  logic                  imem_read;
  logic                  load_pc;
  logic [NUM_STAGES-1:0] stage_load;
  logic [NUM_STAGES-1:0] stage_valid;
  lc3b_pipe_state        ctrl_state;
  logic [CNT_WIDTH-1:0]  stall_count;
  modport master (
    output imem_resp, dmem_req, dmem_resp, branch_taken,
    input  imem_read, load_pc, stage_load, stage_valid, ctrl_state, stall_count
  );
  modport slave (
    input  imem_resp, dmem_req, dmem_resp, branch_taken,
    output imem_read, load_pc, stage_load, stage_valid, ctrl_state, stall_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for an in-order pipeline.
// Priority is flush > data stall > instruction stall > run.
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int MEM_STAGE  = MEM_STAGE_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input logic             clk,
  input logic             rst_n,
  pipeline_ctrl_if.slave  bus
);
  logic [NUM_STAGES-1:1] valid_q, valid_d, ld;
  lc3b_pipe_state state_q, state_d;
  logic istall, dstall, flush, ds, is;
  assign bus.imem_read = rst_n;
  assign istall = bus.imem_read & ~bus.imem_resp;
  assign dstall = valid_q[MEM_STAGE] & bus.dmem_req & ~bus.dmem_resp;
  assign flush  = valid_q[NUM_STAGES-1] & bus.branch_taken;
  assign ds = dstall & ~flush;
  assign is = istall & ~dstall & ~flush;
  always_comb
    state_d = flush ? FLUSH : dstall ? DSTALL : istall ? ISTALL : RUN;
  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_st
    localparam bit HOLD = k <= MEM_STAGE;
    localparam bit BUB  = k == MEM_STAGE + 1;
    localparam bit FIRST = k == 1;
    logic prev;
    if (k == 1) begin : g_first
      assign prev = rst_n;
    end else begin : g_rest
      assign prev = valid_q[k-1];
    end
    assign ld[k] = rst_n & ~(ds & HOLD);
    // A flush also drops a wrong-path data access waiting in the MEM stage.
    assign valid_d[k] = flush ? 1'b0 :
                        (ds & HOLD) ? valid_q[k] :
                        ((ds & BUB) | (is & FIRST)) ? 1'b0 : prev;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      state_q <= RUN;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  assign bus.load_pc     = rst_n & ~(ds | is);
  assign bus.stage_load  = {ld, 1'b0};
  assign bus.stage_valid = {valid_q, rst_n};
  assign bus.ctrl_state  = state_q;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i ((istall | dstall) & ~flush),
    .cnt_o (bus.stall_count)
  );
endmodule
